run_length_ctrl: RTL and testbench

Sequencing controller for the run-length detector datapath. It owns the state register, the run counter and the run-length configuration register, and generates the counter-done condition internally. It samples a serial bit stream `w` and flags when `N` consecutive zeros or `N` consecutive ones have been seen. It sits between the serial input source and any consumer of the detect flags, and also keeps a saturating count of detected runs for status readback.

---
 rtl/run_length_ctrl.sv | 96 +++++++++
 tb/tb_run_length_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/run_length_ctrl.sv
// Run-length detector controller: flags N consecutive zeros or ones on a serial
// stream and keeps a saturating count of detected runs.
module run_length_ctrl #(
   parameter int unsigned CW        = 4,
   parameter int unsigned N_DEFAULT = 4,
   parameter int unsigned DW        = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] n_len,
   input  logic          en,
   input  logic          w,
   output logic          z_zero,
   output logic          z_one,
   output logic          z,
   output logic [2:0]    state,
   output logic [CW-1:0] run_cnt,
   output logic [DW-1:0] det_cnt
);

   typedef enum logic [2:0] {
      S0 = 3'b000,
      S1 = 3'b001,
      S2 = 3'b010,
      S3 = 3'b011,
      S4 = 3'b100
   } state_t;

   logic [CW-1:0] n_reg;
   logic [CW-1:0] n_reg_d;
   logic [2:0]    state_d;
   logic [CW-1:0] run_d;
   logic [DW-1:0] det_d;
   logic [CW-1:0] neff;
   logic [CW-1:0] cand;
   logic          legal;
   logic          in_run;
   logic          run_bit;
   logic          c;

   // Next-state, counter and configuration logic
   always_comb begin
      n_reg_d = n_reg;
      state_d = state;
      run_d   = run_cnt;
      det_d   = det_cnt;
      neff    = (n_reg == '0) ? CW'(1) : n_reg;
      legal   = (state <= S4);
      in_run  = (state != S0) && legal;
      run_bit = (state == S3) || (state == S4);
      cand    = CW'(1);
      // A matching bit extends the run, saturating at the effective length
      if (in_run && (w == run_bit))
         cand = (run_cnt >= neff) ? neff : run_cnt + CW'(1);
      c = (cand == neff);

      if (load) begin
         n_reg_d = n_len;
         state_d = S0;
         run_d   = '0;
      end else if (!legal) begin
         state_d = S0;
         run_d   = '0;
      end else if (en) begin
         if (w) state_d = c ? S4 : S3;
         else   state_d = c ? S2 : S1;
         run_d = cand;
         if (((state_d == S2) || (state_d == S4)) && (state_d != state)
             && (det_cnt != {DW{1'b1}}))
            det_d = det_cnt + DW'(1);
      end
   end

   // State and status registers; detect flags registered alongside the state
   always_ff @(posedge clk) begin
      if (reset) begin
         n_reg   <= CW'(N_DEFAULT);
         state   <= S0;
         run_cnt <= '0;
         det_cnt <= '0;
         z_zero  <= 1'b0;
         z_one   <= 1'b0;
         z       <= 1'b0;
      end else begin
         n_reg   <= n_reg_d;
         state   <= state_d;
         run_cnt <= run_d;
         det_cnt <= det_d;
         z_zero  <= (state_d == S2);
         z_one   <= (state_d == S4);
         z       <= (state_d == S2) || (state_d == S4);
      end
   end

endmodule

// File: tb/tb_run_length_ctrl.sv
// Self-checking bench for run_length_ctrl: vector table through a scoreboard
// queue, plus hand-written reset, saturation and illegal-state sequences.
module tb_run_length_ctrl;

   typedef struct {
      logic       ld;
      logic [3:0] nl;
      logic       en;
      logic       w;
      logic [2:0] st;
      logic [3:0] rc;
      logic [7:0] dc;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, load, en, w;
   logic [3:0] n_len;
   logic       z_zero, z_one, z;
   logic [2:0] state;
   logic [3:0] run_cnt;
   logic [7:0] det_cnt;

   logic       reset2, load2, en2, w2;
   logic [3:0] n_len2;
   logic       z_zero2, z_one2, z2;
   logic [2:0] state2;
   logic [3:0] run_cnt2;
   logic [1:0] det_cnt2;

   int errors = 0;
   int checks = 0;

   vec_t vecs[$];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   run_length_ctrl #(.CW(4), .N_DEFAULT(4), .DW(8)) dut (
      .clk(clk), .reset(reset), .load(load), .n_len(n_len), .en(en), .w(w),
      .z_zero(z_zero), .z_one(z_one), .z(z), .state(state),
      .run_cnt(run_cnt), .det_cnt(det_cnt)
   );

   run_length_ctrl #(.CW(4), .N_DEFAULT(1), .DW(2)) dut2 (
      .clk(clk), .reset(reset2), .load(load2), .n_len(n_len2), .en(en2), .w(w2),
      .z_zero(z_zero2), .z_one(z_one2), .z(z2), .state(state2),
      .run_cnt(run_cnt2), .det_cnt(det_cnt2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input logic ld, input logic [3:0] nl, input logic e,
                               input logic b, input logic [2:0] st, input logic [3:0] rc,
                               input logic [7:0] dc);
      vec_t v;
      v.ld = ld; v.nl = nl; v.en = e; v.w = b; v.st = st; v.rc = rc; v.dc = dc;
      vecs.push_back(v);
   endfunction

   task automatic apply(input int idx, input vec_t v);
      vec_t e;
      @(negedge clk);
      load = v.ld; n_len = v.nl; en = v.en; w = v.w;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d state", idx), 32'(state), 32'(e.st));
      chk($sformatf("v%0d run_cnt", idx), 32'(run_cnt), 32'(e.rc));
      chk($sformatf("v%0d det_cnt", idx), 32'(det_cnt), 32'(e.dc));
      chk($sformatf("v%0d z_zero", idx), 32'(z_zero), 32'(e.st == 3'd2));
      chk($sformatf("v%0d z_one", idx), 32'(z_one), 32'(e.st == 3'd4));
      chk($sformatf("v%0d z", idx), 32'(z), 32'((e.st == 3'd2) || (e.st == 3'd4)));
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; en = 1'b0; w = 1'b0; n_len = 4'd0;
      reset2 = 1'b1; load2 = 1'b0; en2 = 1'b0; w2 = 1'b0; n_len2 = 4'd0;

      // N=4 zeros run, then a fifth zero holds the detect
      add(0, 0, 1, 0, 3'd1, 4'd1, 8'd0);
      add(0, 0, 1, 0, 3'd1, 4'd2, 8'd0);
      add(0, 0, 1, 0, 3'd1, 4'd3, 8'd0);
      add(0, 0, 1, 0, 3'd2, 4'd4, 8'd1);
      add(0, 0, 1, 0, 3'd2, 4'd4, 8'd1);
      // N=3: ones run then zeros run; load overrides en and w
      add(1, 3, 1, 1, 3'd0, 4'd0, 8'd1);
      add(0, 0, 1, 1, 3'd3, 4'd1, 8'd1);
      add(0, 0, 1, 1, 3'd3, 4'd2, 8'd1);
      add(0, 0, 1, 1, 3'd4, 4'd3, 8'd2);
      add(0, 0, 1, 0, 3'd1, 4'd1, 8'd2);
      add(0, 0, 1, 0, 3'd1, 4'd2, 8'd2);
      add(0, 0, 1, 0, 3'd2, 4'd3, 8'd3);
      // N=2 alternating bits never detect
      add(1, 2, 1, 1, 3'd0, 4'd0, 8'd3);
      for (int i = 0; i < 20; i++)
         add(0, 0, 1, 1'(i % 2), (i % 2 == 1) ? 3'd3 : 3'd1, 4'd1, 8'd3);
      // n_len=0 behaves as N=1
      add(1, 0, 1, 1, 3'd0, 4'd0, 8'd3);
      add(0, 0, 1, 0, 3'd2, 4'd1, 8'd4);
      add(0, 0, 1, 1, 3'd4, 4'd1, 8'd5);
      add(0, 0, 1, 1, 3'd4, 4'd1, 8'd5);
      add(0, 0, 1, 0, 3'd2, 4'd1, 8'd6);
      // N=4 partial run discarded by load, then en gaps inside a run
      add(1, 4, 1, 1, 3'd0, 4'd0, 8'd6);
      add(0, 0, 1, 0, 3'd1, 4'd1, 8'd6);
      add(0, 0, 1, 0, 3'd1, 4'd2, 8'd6);
      add(0, 0, 1, 0, 3'd1, 4'd3, 8'd6);
      add(1, 4, 1, 0, 3'd0, 4'd0, 8'd6);
      add(0, 0, 1, 0, 3'd1, 4'd1, 8'd6);
      add(0, 0, 1, 0, 3'd1, 4'd2, 8'd6);
      for (int i = 0; i < 5; i++)
         add(0, 0, 0, 1, 3'd1, 4'd2, 8'd6);
      add(0, 0, 1, 0, 3'd1, 4'd3, 8'd6);
      add(0, 0, 1, 0, 3'd2, 4'd4, 8'd7);
      add(0, 0, 1, 1, 3'd3, 4'd1, 8'd7);
      add(0, 0, 1, 1, 3'd3, 4'd2, 8'd7);

      repeat (2) @(posedge clk);
      #1;
      chk("reset state", 32'(state), 32'd0);
      chk("reset run_cnt", 32'(run_cnt), 32'd0);
      chk("reset det_cnt", 32'(det_cnt), 32'd0);
      chk("reset z", 32'({z_zero, z_one, z}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      reset2 = 1'b0;

      for (int i = 0; i < vecs.size(); i++)
         apply(i, vecs[i]);

      // Reset mid-run clears everything, then a fresh run starts
      @(negedge clk);
      reset = 1'b1; en = 1'b1; w = 1'b1;
      @(posedge clk);
      #1;
      chk("midreset state", 32'(state), 32'd0);
      chk("midreset run_cnt", 32'(run_cnt), 32'd0);
      chk("midreset det_cnt", 32'(det_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0; w = 1'b0;
      @(posedge clk);
      #1;
      chk("postreset state", 32'(state), 32'd1);
      chk("postreset run_cnt", 32'(run_cnt), 32'd1);

      // DW=2, N=1: toggling detects every bit and det_cnt saturates at 3
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         en2 = 1'b1; w2 = 1'(i % 2);
         @(posedge clk);
         #1;
         chk($sformatf("sat%0d state", i), 32'(state2), (i % 2 == 1) ? 32'd4 : 32'd2);
         chk($sformatf("sat%0d det_cnt", i), 32'(det_cnt2), (i < 3) ? 32'(i + 1) : 32'd3);
      end

      // Illegal state code recovers to S0 with run_cnt cleared
      @(negedge clk);
      en2 = 1'b1; w2 = 1'b0;
      force dut2.state = 3'b110;
      #1;
      release dut2.state;
      chk("forced state", 32'(state2), 32'd6);
      @(posedge clk);
      #1;
      chk("illegal state", 32'(state2), 32'd0);
      chk("illegal run_cnt", 32'(run_cnt2), 32'd0);
      chk("illegal z", 32'(z2), 32'd0);
      chk("illegal det_cnt", 32'(det_cnt2), 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
